qspi_page_programmer: RTL and testbench



---
 rtl/qspi_page_programmer.sv | 245 ++++++++++++++++++++++++
 tb/tb_qspi_page_programmer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_page_programmer.sv
// qspi_page_programmer: sequences RDID, quad switch, optional sector erase and
// NUM_PAGES page programs through qspi_mem_controller, polling WIP after each
// write. It reports progress and a coded pass/fail result.
module qspi_page_programmer #(
  parameter int unsigned PAGE_BYTES = 256,
  parameter int unsigned NUM_PAGES  = 1,
  parameter logic [23:0] START_ADDR = 24'hA30000,
  parameter bit          ERASE_EN   = 1'b1,
  parameter logic [7:0]  JEDEC_ID   = 8'h20,
  parameter logic [7:0]  EXP_ID     = JEDEC_ID,
  parameter int unsigned POLL_LIMIT = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          page_req,
  output logic [11:0]                   page_idx,
  input  logic                          page_valid,
  input  logic [PAGE_BYTES*8-1:0]       page_data,
  output logic                          trigger,
  output logic                          quad,
  output logic [7:0]                    cmd,
  output logic [(3+PAGE_BYTES)*8-1:0]   data_send,
  input  logic [7:0]                    readout,
  input  logic                          busy,
  input  logic                          error,
  output logic                          running,
  output logic                          done,
  output logic                          fail,
  output logic [1:0]                    fail_code,
  output logic [12:0]                   pages_done
);

  localparam int unsigned DW  = (3 + PAGE_BYTES) * 8;
  localparam int unsigned PW  = PAGE_BYTES * 8;
  localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);

  localparam logic [7:0] CMD_RDID   = 8'h9F;
  localparam logic [7:0] CMD_WRVECR = 8'h61;
  localparam logic [7:0] CMD_WREN   = 8'h06;
  localparam logic [7:0] CMD_SE     = 8'hD8;
  localparam logic [7:0] CMD_RDSR   = 8'h05;
  localparam logic [7:0] CMD_PP     = 8'h02;
  // Enhanced volatile config: quad I/O enabled, hold disabled, default dummies.
  localparam logic [7:0] VECR_QUAD  = 8'b010_01_111;

  typedef enum logic [3:0] {
    S_IDLE, S_RDID, S_WRVECR, S_WREN_E, S_SE, S_POLL_E, S_REQ, S_LOAD,
    S_WREN_P, S_PP, S_POLL_P, S_NEXT, S_DONE, S_FAIL
  } state_e;

  // Every command state walks ISSUE (load cmd, raise trigger) -> PULSE
  // (trigger high) -> WAIT (until the controller is idle again).
  typedef enum logic [1:0] {PH_ISSUE, PH_PULSE, PH_WAIT} phase_e;

  state_e          state_q;
  phase_e          phase_q;
  logic            trigger_q, quad_q, page_req_q, running_q, done_q, fail_q;
  logic [7:0]      cmd_q, cmd_d;
  logic [DW-1:0]   data_send_q, data_send_d;
  logic [11:0]     page_idx_q;
  logic [1:0]      fail_code_q;
  logic [12:0]     pages_done_q;
  logic [23:0]     addr_q;
  logic [PW-1:0]   page_buf_q;
  logic [PCW-1:0]  poll_cnt_q;

  logic            cmd_cmpl;
  logic [12:0]     pages_next;
  logic [23:0]     addr_next;

  assign cmd_cmpl   = (phase_q == PH_WAIT) && !trigger_q && !busy;
  assign pages_next = pages_done_q + 13'd1;
  assign addr_next  = addr_q + 24'(PAGE_BYTES);

  // Command and payload the current state would issue.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    cmd_d       = CMD_RDSR;
    data_send_d = '0;
    case (state_q)
      S_RDID:             cmd_d = CMD_RDID;
      S_WRVECR: begin
        cmd_d            = CMD_WRVECR;
        data_send_d[7:0] = VECR_QUAD;
      end
      S_WREN_E, S_WREN_P: cmd_d = CMD_WREN;
      S_SE: begin
        cmd_d             = CMD_SE;
        data_send_d[23:0] = addr_q;
      end
      S_PP: begin
        cmd_d       = CMD_PP;
        data_send_d = {addr_q, page_buf_q};
      end
      default:            cmd_d = CMD_RDSR;
    endcase
  end

  // Sequencer FSM with registered command port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_ISSUE;
      trigger_q    <= 1'b0;
      quad_q       <= 1'b0;
      page_req_q   <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= 2'd0;
      pages_done_q <= 13'd0;
      page_idx_q   <= 12'd0;
      cmd_q        <= 8'd0;
      data_send_q  <= '0;
      addr_q       <= START_ADDR;
      page_buf_q   <= '0;
      poll_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
      trigger_q  <= 1'b0;
      page_req_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state_q      <= S_RDID;
            phase_q      <= PH_ISSUE;
            running_q    <= 1'b1;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= 2'd0;
            pages_done_q <= 13'd0;
            addr_q       <= START_ADDR;
          end
        end
        S_REQ: begin
          page_req_q <= 1'b1;
          page_idx_q <= pages_done_q[11:0];
          state_q    <= S_LOAD;
        end
        S_LOAD: begin
          // A strobe coinciding with the request pulse is too early to accept.
          if (page_valid && !page_req_q) begin
            page_buf_q <= page_data;
            state_q    <= S_WREN_P;
            phase_q    <= PH_ISSUE;
          end
        end
        S_NEXT: begin
          phase_q <= PH_ISSUE;
          if (ERASE_EN && (addr_q[15:0] == 16'd0)) state_q <= S_WREN_E;
          else                                      state_q <= S_REQ;
        end
        default: begin
          case (phase_q)
            PH_ISSUE: begin
              trigger_q   <= 1'b1;
              cmd_q       <= cmd_d;
              data_send_q <= data_send_d;
              phase_q     <= PH_PULSE;
            end
            PH_PULSE: phase_q <= PH_WAIT;
            default: begin
              if (cmd_cmpl) begin
                phase_q <= PH_ISSUE;
                if (error) begin
                  state_q     <= S_FAIL;
                  fail_q      <= 1'b1;
                  fail_code_q <= 2'd2;
                  running_q   <= 1'b0;
                end else begin
                  case (state_q)
                    S_RDID: begin
                      if (readout != EXP_ID) begin
                        state_q     <= S_FAIL;
                        fail_q      <= 1'b1;
                        fail_code_q <= 2'd1;
                        running_q   <= 1'b0;
                      end else begin
                        state_q <= S_WRVECR;
                      end
                    end
                    S_WRVECR: begin
                      quad_q  <= 1'b1;
                      state_q <= ERASE_EN ? S_WREN_E : S_REQ;
                    end
                    S_WREN_E: state_q <= S_SE;
                    S_SE: begin
                      state_q    <= S_POLL_E;
                      poll_cnt_q <= '0;
                    end
                    S_WREN_P: state_q <= S_PP;
                    S_PP: begin
                      state_q    <= S_POLL_P;
                      poll_cnt_q <= '0;
                    end
                    S_POLL_E, S_POLL_P: begin
                      if (!readout[0]) begin
                        if (state_q == S_POLL_E) begin
                          state_q <= S_REQ;
                        end else begin
                          // Finish the page here so done/running move right after this completion.
                          pages_done_q <= pages_next;
                          addr_q       <= addr_next;
                          if (pages_next == 13'(NUM_PAGES)) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            running_q <= 1'b0;
                          end else begin
                            state_q <= S_NEXT;
                          end
                        end
                      end else if (32'(poll_cnt_q) + 32'd1 == POLL_LIMIT) begin
                        state_q     <= S_FAIL;
                        fail_q      <= 1'b1;
                        fail_code_q <= 2'd3;
                        running_q   <= 1'b0;
                      end else begin
                        poll_cnt_q <= poll_cnt_q + 1'b1;
                      end
                    end
                    default: state_q <= S_IDLE;
                  endcase
                end
              end
            end
          endcase
        end
      endcase
    end
  end

  assign trigger    = trigger_q;
  assign quad       = quad_q;
  assign cmd        = cmd_q;
  assign data_send  = data_send_q;
  assign page_req   = page_req_q;
  assign page_idx   = page_idx_q;
  assign running    = running_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_code  = fail_code_q;
  assign pages_done = pages_done_q;

endmodule

// File: tb/tb_qspi_page_programmer.sv
// Directed bench for qspi_page_programmer: controller/flash response model,
// page source, command log, and a linear sequence of checked scenarios.
module tb_qspi_page_programmer;

  localparam int          PB   = 256;
  localparam int          NP   = 2;
  localparam logic [23:0] SA   = 24'hA3FF00;
  localparam int          PL   = 4;
  localparam logic [7:0]  ID   = 8'h20;
  localparam int          DW   = (3 + PB) * 8;
  localparam int          PW   = PB * 8;

  localparam logic [7:0] C_RDID = 8'h9F, C_WRVECR = 8'h61, C_WREN = 8'h06;
  localparam logic [7:0] C_SE   = 8'hD8, C_RDSR   = 8'h05, C_PP   = 8'h02;

  logic            clk = 1'b0;
  logic            rst, start;
  logic            page_req, page_valid;
  logic [11:0]     page_idx;
  logic [PW-1:0]   page_data;
  logic            trigger, quad, busy, error;
  logic [7:0]      cmd, readout;
  logic [DW-1:0]   data_send;
  logic            running, done, fail;
  logic [1:0]      fail_code;
  logic [12:0]     pages_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0]    cmd;
    logic [DW-1:0] data;
    int            cyc;
  } cmd_t;
  cmd_t log_q[$];
  int   valid_q[$];

  // Scenario knobs driven from the initial block.
  logic [7:0] m_id;
  logic       m_err_pp, m_stuck_pp, glitch_en;

  qspi_page_programmer #(
    .PAGE_BYTES(PB), .NUM_PAGES(NP), .START_ADDR(SA), .ERASE_EN(1'b1),
    .JEDEC_ID(ID), .EXP_ID(ID), .POLL_LIMIT(PL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .page_req(page_req), .page_idx(page_idx), .page_valid(page_valid), .page_data(page_data),
    .trigger(trigger), .quad(quad), .cmd(cmd), .data_send(data_send),
    .readout(readout), .busy(busy), .error(error),
    .running(running), .done(done), .fail(fail), .fail_code(fail_code), .pages_done(pages_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] pattern(input logic [11:0] idx);
    logic [PW-1:0] p;
    for (int k = 0; k < PB; k++) p[PW-1-8*k -: 8] = 8'(k) ^ {idx[3:0], 4'hA};
    return p;
  endfunction

  // Controller + flash model: busy for a few cycles per command, WIP set for one poll after writes.
  logic [7:0] m_cmd;
  int         m_cnt, wip_left;
  logic       wip_stuck;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0; error <= 1'b0; readout <= 8'h00; m_cmd <= 8'h00;
      m_cnt <= 0; wip_left <= 0; wip_stuck <= 1'b0;
    end else if (trigger) begin
      log_q.push_back('{cmd, data_send, cyc});
      busy <= 1'b1; error <= 1'b0; m_cnt <= 2; m_cmd <= cmd;
    end else if (busy) begin
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else begin
        busy <= 1'b0;
        case (m_cmd)
          C_RDID: begin readout <= m_id; wip_stuck <= 1'b0; end
          C_RDSR: begin
            if (wip_stuck || wip_left != 0) begin
              readout <= 8'h01;
              if (wip_left != 0) wip_left <= wip_left - 1;
            end else readout <= 8'h00;
          end
          C_SE: wip_left <= 1;
          C_PP: begin wip_left <= 1; wip_stuck <= m_stuck_pp; error <= m_err_pp; end
          default: ;
        endcase
      end
    end
  end

  // Page source: answers page_req three cycles later with a one-cycle strobe.
  int         src_cnt;
  logic       src_vld;
  logic [11:0] src_idx;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      src_cnt <= 0; src_vld <= 1'b0; src_idx <= 12'd0;
    end else begin
      src_vld <= (src_cnt == 1);
      if (page_req) begin src_cnt <= 3; src_idx <= page_idx; end
      else if (src_cnt != 0) src_cnt <= src_cnt - 1;
    end
  end
  assign page_valid = src_vld | (glitch_en & page_req);
  assign page_data  = src_vld ? pattern(src_idx) : {PB{8'hEE}};

  always @(posedge clk) if (src_vld) valid_q.push_back(cyc);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(done || fail) && n < budget) begin tick(); n++; end
    check(tag, 64'(done || fail), 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [7:0] log_cmd(input int i);
    if (i < log_q.size()) return log_q[i].cmd;
    return 8'hxx;
  endfunction

  function automatic logic [23:0] log_addr(input int i, input bit is_pp);
    if (i >= log_q.size()) return 24'hxxxxxx;
    return is_pp ? log_q[i].data[DW-1 -: 24] : log_q[i].data[23:0];
  endfunction

  function automatic int count_cmd(input int from, input logic [7:0] c);
    int n = 0;
    for (int i = from; i < log_q.size(); i++) if (log_q[i].cmd == c) n++;
    return n;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_trigger"},    64'(trigger),    64'd0);
    check({pfx, "_quad"},       64'(quad),       64'd0);
    check({pfx, "_page_req"},   64'(page_req),   64'd0);
    check({pfx, "_running"},    64'(running),    64'd0);
    check({pfx, "_done"},       64'(done),       64'd0);
    check({pfx, "_fail"},       64'(fail),       64'd0);
    check({pfx, "_fail_code"},  64'(fail_code),  64'd0);
    check({pfx, "_pages_done"}, 64'(pages_done), 64'd0);
    check({pfx, "_page_idx"},   64'(page_idx),   64'd0);
    check({pfx, "_cmd"},        64'(cmd),        64'd0);
    check({pfx, "_data_send"},  64'(|data_send), 64'd0);
  endtask

  initial begin
    logic [7:0]  exp_run [18];
    int          base, vbase, n;

    exp_run = '{C_RDID, C_WRVECR, C_WREN, C_SE, C_RDSR, C_RDSR, C_WREN, C_PP, C_RDSR, C_RDSR,
                C_WREN, C_SE, C_RDSR, C_RDSR, C_WREN, C_PP, C_RDSR, C_RDSR};

    rst = 1'b1; start = 1'b0; m_id = ID; m_err_pp = 1'b0; m_stuck_pp = 1'b0; glitch_en = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Wrong ID: fail code 1, nothing after RDID, quad untouched.
    m_id = 8'h00;
    base = log_q.size();
    pulse_start();
    check("id_lat1_trigger", 64'(trigger), 64'd0);
    check("id_running",      64'(running), 64'd1);
    tick();
    check("id_lat2_trigger", 64'(trigger), 64'd1);
    check("id_cmd_rdid",     64'(cmd),     64'(C_RDID));
    wait_end("id_end", 500);
    check("id_fail",      64'(fail),      64'd1);
    check("id_fail_code", 64'(fail_code), 64'd1);
    check("id_done",      64'(done),      64'd0);
    check("id_running0",  64'(running),   64'd0);
    check("id_quad",      64'(quad),      64'd0);
    check("id_ncmds",     64'(log_q.size() - base), 64'd1);

    // Full two-page run crossing a sector boundary; an early strobe is offered with bad data.
    m_id = ID; glitch_en = 1'b1;
    base = log_q.size(); vbase = valid_q.size();
    pulse_start();
    check("run_fail_cleared", 64'(fail), 64'd0);
    wait_end("run_end", 3000);
    check("run_done",       64'(done),       64'd1);
    check("run_fail",       64'(fail),       64'd0);
    check("run_running",    64'(running),    64'd0);
    check("run_pages_done", 64'(pages_done), 64'd2);
    check("run_quad",       64'(quad),       64'd1);
    check("run_ncmds",      64'(log_q.size() - base), 64'd18);
    for (int i = 0; i < 18; i++)
      check($sformatf("run_cmd%0d", i), 64'(log_cmd(base + i)), 64'(exp_run[i]));
    check("run_vecr_data", 64'(log_q[base + 1].data[7:0]), 64'h4F);
    check("run_se0_addr",  64'(log_addr(base + 3, 1'b0)),  64'hA3FF00);
    check("run_pp0_addr",  64'(log_addr(base + 7, 1'b1)),  64'hA3FF00);
    check("run_se1_addr",  64'(log_addr(base + 11, 1'b0)), 64'hA40000);
    check("run_pp1_addr",  64'(log_addr(base + 15, 1'b1)), 64'hA40000);
    check("run_pp0_data",  64'(log_q[base + 7].data[PW-1:0] === pattern(12'd0)), 64'd1);
    check("run_pp1_data",  64'(log_q[base + 15].data[PW-1:0] === pattern(12'd1)), 64'd1);
    check("run_valid_to_wren", 64'(log_q[base + 6].cyc - valid_q[vbase]), 64'd2);
    glitch_en = 1'b0;

    // WIP never clears after the first PP: exactly four polls, then code 3.
    m_stuck_pp = 1'b1;
    base = log_q.size();
    pulse_start();
    check("to_done_cleared",  64'(done),       64'd0);
    check("to_pages_cleared", 64'(pages_done), 64'd0);
    wait_end("to_end", 3000);
    check("to_fail_code",  64'(fail_code), 64'd3);
    check("to_pages_done", 64'(pages_done), 64'd0);
    check("to_quad_kept",  64'(quad), 64'd1);
    check("to_pp_cmd",     64'(log_cmd(base + 7)), 64'(C_PP));
    check("to_ncmds",      64'(log_q.size() - base), 64'd12);
    check("to_rdsr_after_pp", 64'(count_cmd(base + 8, C_RDSR)), 64'd4);
    m_stuck_pp = 1'b0;

    // Controller error on the first PP completion: code 2; then a clean restart.
    m_err_pp = 1'b1;
    base = log_q.size();
    pulse_start();
    wait_end("err_end", 3000);
    check("err_fail",       64'(fail),       64'd1);
    check("err_fail_code",  64'(fail_code),  64'd2);
    check("err_pages_done", 64'(pages_done), 64'd0);
    check("err_last_cmd",   64'(log_cmd(log_q.size() - 1)), 64'(C_PP));
    m_err_pp = 1'b0;
    base = log_q.size();
    pulse_start();
    check("rs_fail",      64'(fail),      64'd0);
    check("rs_fail_code", 64'(fail_code), 64'd0);
    check("rs_running",   64'(running),   64'd1);
    tick();
    check("rs_trigger",   64'(trigger),   64'd1);
    check("rs_cmd",       64'(cmd),       64'(C_RDID));
    wait_end("rs_end", 3000);
    check("rs_done",       64'(done),       64'd1);
    check("rs_pages_done", 64'(pages_done), 64'd2);

    // Reset while the second PP is in flight.
    base = log_q.size();
    pulse_start();
    n = 0;
    while (count_cmd(base, C_PP) < 2 && n < 3000) begin tick(); n++; end
    check("rst_pp2_seen", 64'(count_cmd(base, C_PP)), 64'd2);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    base = log_q.size();
    repeat (50) tick();
    check("midrst_no_trigger", 64'(log_q.size() - base), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
